pkt_sort_buffer: RTL and testbench
==================================

PKT_SORT_BUFFER -- requirements
Module: pkt_sort_buffer

Interface
REQ-001 Parameter: BUFFER_SIZE, default 16, number of packet slots; must be a power of two and at least 2.
REQ-002 Parameter: HEADER_MAGIC, default 8'hA5, required value of in_data[31:24] for a packet to be valid.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream write beat present.
REQ-006 in_ready  output  1  buffer accepts a beat this cycle.
REQ-007 in_data  input  32  packet word: [31:24] header, [23:8] payload, [7:0] sort key.
REQ-008 in_commit  input  1  single-cycle pulse that ends filling and starts draining.
REQ-009 out_valid  output  1  sorted packet available.
REQ-010 out_ready  input  1  downstream accepts the packet.
REQ-011 out_data  output  32  current lowest-key packet.
REQ-012 out_last  output  1  out_data is the final packet of this drain.
REQ-013 count  output  $clog2(BUFFER_SIZE)+1  number of occupied slots.
REQ-014 drop_count  output  16  packets rejected for a bad header; saturates at 16'hFFFF.
REQ-015 busy  output  1  high while in DRAIN state.

Function
REQ-016 The state machine SHALL have two states, FILL and DRAIN.
REQ-017 In FILL: in_ready = (count < BUFFER_SIZE), out_valid = 0.
REQ-018 A beat is accepted when in_valid && in_ready; on an accepted beat with in_data[31:24] == HEADER_MAGIC, the word SHALL be inserted in ascending key order in the same cycle, and count SHALL increment by 1 on the next edge.
REQ-019 Insertion SHALL be stable: a new word goes after all stored words with an equal key.
REQ-020 An accepted beat with a bad header SHALL NOT be stored, and drop_count SHALL increment by 1 (saturating).
REQ-021 When full, in_ready = 0; beats are not accepted and drop_count SHALL NOT change.
REQ-022 FILL to DRAIN: in_commit high in FILL with count > 0, or with a valid beat accepted in that same cycle; that same-cycle beat SHALL be included in the drain.
REQ-023 in_commit in FILL with count == 0 and no valid beat accepted SHALL be ignored.
REQ-024 In DRAIN: in_ready = 0, out_valid = (count > 0), out_data = slot 0, out_last = (count == 1); in_commit SHALL be ignored.
REQ-025 When out_valid && out_ready, slots SHALL shift down by one and count SHALL decrement on the next edge.
REQ-026 out_valid/out_data SHALL stay stable until accepted.
REQ-027 DRAIN to FILL SHALL happen on the edge where the out_last packet is accepted, so in_ready is 1 in the next cycle.
REQ-028 Insert-to-visible latency: a stored word SHALL be present in slot order one cycle after acceptance.
REQ-029 Commit-to-output latency: out_valid SHALL be high in the cycle after the commit edge.

Reset
REQ-030 While rst_n == 0 at posedge, the block SHALL force: state FILL, count 0, drop_count 0, all slots 0, out_valid 0, out_last 0, busy 0.
REQ-031 in_ready SHALL be 0 during reset.
REQ-032 Reset in mid-DRAIN SHALL discard all stored packets; no further out_valid until a new fill and commit.

Structure
REQ-033 Package pkt_pkg SHALL hold HEADER_MAGIC default, the key field position [7:0], the header field position [31:24], and the state enum {FILL, DRAIN}.
REQ-034 Sub-module pkt_sort_cell (one slot) SHALL hold a data register, an occupied flag, and a compare "new key < my key", and SHALL choose among hold, take the new word, take the left neighbour's word (insert), or take the right neighbour's word (pop).
REQ-035 pkt_sort_buffer SHALL instantiate BUFFER_SIZE cells, the FSM, count, and drop_count.

Verification
REQ-036 Fill with keys 0x30, 0x10, 0x20 (header A5), then commit -> out_data keys in order 0x10, 0x20, 0x30; out_last only on 0x30; busy drops after the last pop.
REQ-037 Send words 0xA5000105 then 0xA5000205 (equal key 0x05) -> drained in arrival order, payload 0x0001 before 0x0002.
REQ-038 Send 0x5A0000FF and 0xA50000FF -> drop_count = 1, count = 1.
REQ-039 Write 17 valid beats with BUFFER_SIZE 16 -> in_ready = 0 after 16 beats, 17th beat stalls, count = 16; commit and out_ready held low -> out_data stable.
REQ-040 in_commit with count = 0 -> stays FILL; in_valid + in_commit in the same cycle with key 0x07 -> DRAIN with one packet, out_last = 1.
REQ-041 Assert rst_n = 0 after two pops of a 5-packet drain -> next cycle count = 0, out_valid = 0, in_ready = 1 after reset release.

Source files
------------

// File: rtl/pkt_pkg.sv
// =============================================================================
// pkt_pkg : shared field positions, header default and FSM state encoding
// Revision: 1.0
// =============================================================================
`default_nettype none

package pkt_pkg;

  localparam logic [7:0] HEADER_MAGIC_DEFAULT = 8'hA5;

  localparam int KEY_MSB = 7;
  localparam int KEY_LSB = 0;
  localparam int HDR_MSB = 31;
  localparam int HDR_LSB = 24;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic logic [7:0] key_of(input logic [31:0] word);
    return word[KEY_MSB:KEY_LSB];
  endfunction

  function automatic logic [7:0] hdr_of(input logic [31:0] word);
    return word[HDR_MSB:HDR_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_sort_cell.sv
// =============================================================================
// pkt_sort_cell : one slot of the insertion-sort shift register
// Revision: 1.0
// =============================================================================
`default_nettype none

module pkt_sort_cell
  import pkt_pkg::*;
#(
  parameter bit FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        insert,
  input  logic        pop,
  input  logic [31:0] new_data,
  input  logic [31:0] left_data,
  input  logic        left_occ,
  input  logic [31:0] right_data,
  input  logic        right_occ,
  output logic [31:0] data,
  output logic        occ
);

  logic new_lt_mine;
  logic ins_here;
  logic left_ins;

  // Strict less-than keeps equal keys in arrival order.
  assign new_lt_mine = key_of(new_data) < key_of(data);
  assign ins_here    = !occ || new_lt_mine;
  assign left_ins    = !FIRST && (!left_occ || (key_of(new_data) < key_of(left_data)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
      occ  <= 1'b0;
    end else if (pop) begin
      data <= right_data;
      occ  <= right_occ;
    end else if (insert && ins_here) begin
      if (left_ins) begin
        data <= left_data;
        occ  <= left_occ;
      end else begin
        data <= new_data;
        occ  <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pkt_sort_buffer.sv
// =============================================================================
// pkt_sort_buffer : fill-then-drain buffer emitting packets in ascending key
// Revision: 1.0
// =============================================================================
`default_nettype none

module pkt_sort_buffer
  import pkt_pkg::*;
#(
  parameter int         BUFFER_SIZE  = 16,
  parameter logic [7:0] HEADER_MAGIC = HEADER_MAGIC_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_data,
  input  logic                           in_commit,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_data,
  output logic                           out_last,
  output logic [$clog2(BUFFER_SIZE):0]   count,
  output logic [15:0]                    drop_count,
  output logic                           busy
);

  localparam int CW = $clog2(BUFFER_SIZE) + 1;

  state_t      state;
  logic [31:0] slot_data [BUFFER_SIZE];
  logic [BUFFER_SIZE-1:0] slot_occ;

  logic accept;
  logic good;
  logic bad;
  logic pop;

  assign in_ready  = rst_n && (state == FILL) && (count < CW'(BUFFER_SIZE));
  assign accept    = in_valid && in_ready;
  assign good      = accept && (hdr_of(in_data) == HEADER_MAGIC);
  assign bad       = accept && (hdr_of(in_data) != HEADER_MAGIC);
  assign out_valid = (state == DRAIN) && (count != '0);
  assign out_last  = (state == DRAIN) && (count == CW'(1));
  assign out_data  = slot_data[0];
  assign busy      = (state == DRAIN);
  assign pop       = out_valid && out_ready;

  generate
    for (genvar i = 0; i < BUFFER_SIZE; i++) begin : g_cell
      logic [31:0] l_data;
      logic        l_occ;
      logic [31:0] r_data;
      logic        r_occ;

      if (i == 0) begin : g_head
        assign l_data = '0;
        assign l_occ  = 1'b1;
      end else begin : g_left
        assign l_data = slot_data[i-1];
        assign l_occ  = slot_occ[i-1];
      end

      if (i == BUFFER_SIZE - 1) begin : g_tail
        assign r_data = '0;
        assign r_occ  = 1'b0;
      end else begin : g_right
        assign r_data = slot_data[i+1];
        assign r_occ  = slot_occ[i+1];
      end

      pkt_sort_cell #(
        .FIRST (i == 0)
      ) u_cell (
        .clk        (clk),
        .rst_n      (rst_n),
        .insert     (good),
        .pop        (pop),
        .new_data   (in_data),
        .left_data  (l_data),
        .left_occ   (l_occ),
        .right_data (r_data),
        .right_occ  (r_occ),
        .data       (slot_data[i]),
        .occ        (slot_occ[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL;
      count      <= '0;
      drop_count <= '0;
    end else begin
      case (state)
        FILL: begin
          if (good) count <= count + CW'(1);
          if (bad && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
          // A beat stored in the commit cycle counts toward the drain.
          if (in_commit && ((count != '0) || good)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop) begin
            count <= count - CW'(1);
            if (count == CW'(1)) state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pkt_sort_buffer.sv
// =============================================================================
// tb_pkt_sort_buffer : scoreboard bench with a queue-based sorted-buffer model
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_pkt_sort_buffer;

  localparam int BS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_commit = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic [4:0]  count;
  logic [15:0] drop_count;
  logic        busy;

  pkt_sort_buffer #(.BUFFER_SIZE(BS), .HEADER_MAGIC(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_commit  (in_commit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .count      (count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model: a plain queue kept sorted, plus the expected output stream.
  logic [31:0] mbuf [$];
  logic [31:0] exp_q [$];
  bit          m_drain = 0;
  int          m_drop  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_insert(input logic [31:0] w);
    int j;
    j = 0;
    while (j < mbuf.size() && mbuf[j][7:0] <= w[7:0]) j++;
    mbuf.insert(j, w);
  endtask

  // One clock cycle: drive, check state-level outputs, then advance the model.
  task automatic step(input logic v, input logic [31:0] d, input logic c,
                      input logic r, input logic ordy);
    bit acc;
    in_valid  = v;
    in_data   = d;
    in_commit = c;
    rst_n     = r;
    out_ready = ordy;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(r && !m_drain && mbuf.size() < BS));
    check("count", 32'(count), 32'(mbuf.size()));
    check("busy", 32'(busy), 32'(m_drain));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    @(posedge clk);
    if (!r) begin
      mbuf.delete();
      exp_q.delete();
      m_drain = 0;
      m_drop  = 0;
    end else if (!m_drain) begin
      acc = v && mbuf.size() < BS;
      if (acc && d[31:24] == 8'hA5) model_insert(d);
      else if (acc && m_drop < 65535) m_drop++;
      if (c && mbuf.size() > 0) begin
        m_drain = 1;
        exp_q = mbuf;
      end
    end else if (ordy && mbuf.size() > 0) begin
      void'(mbuf.pop_front());
      if (mbuf.size() == 0) m_drain = 0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic beat(input logic [31:0] d);
    step(1'b1, d, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain_all(input int ready_pct);
    int guard;
    guard = 0;
    while (m_drain && guard < 300) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, ($urandom_range(99) < ready_pct));
      guard++;
    end
    if (m_drain) begin
      errors++;
      $display("FAIL drain_timeout: drain did not finish, %0d packets left", mbuf.size());
    end
  endtask

  // Monitor: every presented packet must match the scoreboard head.
  bit mon_en = 0;
  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL spurious_out_valid: out_data 0x%0h with nothing expected", out_data);
      end else begin
        check("out_data", out_data, exp_q[0]);
        check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    int n;
    #1;
    mon_en = 1;
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // Basic ordering
    beat(32'hA5000030);
    beat(32'hA5000010);
    beat(32'hA5000020);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("valid_after_commit", 32'(out_valid), 32'd1);
    drain_all(100);
    idle(1);

    // Equal keys drain in arrival order
    beat(32'hA5000105);
    beat(32'hA5000205);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drain_all(60);

    // Bad header dropped
    beat(32'h5A0000FF);
    beat(32'hA50000FF);
    check("drop_after_bad", 32'(drop_count), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    drain_all(100);

    // Overfill, then hold out_ready low
    for (int k = 0; k < 17; k++) beat({8'hA5, 16'(k), 8'($urandom_range(255))});
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle(4);
    drain_all(100);

    // Empty commit ignored; same-cycle beat plus commit
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 32'hA5000007, 1'b1, 1'b1, 1'b0);
    check("single_last", 32'(out_last), 32'd1);
    drain_all(100);

    // Reset in mid-drain
    for (int k = 0; k < 5; k++) beat({8'hA5, 16'h0, 8'(50 - k)});
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    idle(3);

    // Randomized rounds with duplicate-prone keys and random backpressure
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(20);
      for (int k = 0; k < n; k++) begin
        w = {(($urandom_range(9) == 0) ? 8'($urandom_range(255)) : 8'hA5),
             16'($urandom), 8'($urandom_range(15))};
        step($urandom_range(3) != 0, w, (k == n - 1) && $urandom_range(1), 1'b1, 1'b0);
      end
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      drain_all(30 + 10 * (r % 7));
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
